// File: rtl/single_port_memory_module.sv
// rtl/single_port_memory_module.sv - single-port synchronous memory with registered read and async reset
//
// Purpose: depth x width word store with one access per clock. When we is high
// the word on data_in is written; when it is low the addressed word is loaded
// into data_out. Out-of-range writes are dropped and out-of-range reads load zero.
// data_out holds its value during writes. Reset clears every word and data_out
// asynchronously.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   we       in   1      1 = write, 0 = read
//   addr     in   AW     word address for both write and read
//   data_in  in   width  write data
//   data_out out  width  registered read data, one clock of latency
module single_port_memory_module #(
    parameter int width = 32,
    parameter int depth = 8,
    localparam int AW = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] data_out
);

    // One extra bit so depth itself fits and the range compare cannot wrap.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(depth);

    logic [width-1:0] mem_q [0:depth-1];
    logic [width-1:0] mem_d [0:depth-1];
    logic [width-1:0] data_out_q;
    logic [width-1:0] data_out_d;
    logic             in_range;

    assign in_range = ({1'b0, addr} < DEPTH_W);

    always_comb begin
        mem_d      = mem_q;
        data_out_d = data_out_q;
        if (we) begin
            // data_out is left untouched on a write (no-change mode).
            if (in_range) begin
                mem_d[addr] = data_in;
            end
        end else begin
            data_out_d = in_range ? mem_q[addr] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_single_port_memory_module.sv
// tb/tb_single_port_memory_module.sv - directed self-checking bench for single_port_memory_module
module tb_single_port_memory_module;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int n_cmp;
    int n_bad;

    single_port_memory_module #(
        .width(32),
        .depth(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        we      = 1'b1;
        addr    = a;
        data_in = d;
        tick();
    endtask

    task automatic do_read(input logic [2:0] a);
        we      = 1'b0;
        addr    = a;
        data_in = 32'h0;
        tick();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        we      = 1'b0;
        addr    = 3'd0;
        data_in = 32'h0;

        // Reset takes effect before the first clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", data_out, 32'h0);

        // Attempted write while reset is held must be blocked.
        we      = 1'b1;
        addr    = 3'd2;
        data_in = 32'hFFFF_FFFF;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            check($sformatf("reset_read_%0d", i), data_out, 32'h0);
        end

        // Basic write then read.
        do_write(3'd3, 32'hA5A5_A5A5);
        do_read(3'd3);
        check("wr_rd_addr3", data_out, 32'hA5A5_A5A5);

        // data_out holds during a write.
        do_write(3'd5, 32'hDEAD_BEEF);
        check("no_change_on_write", data_out, 32'hA5A5_A5A5);
        do_read(3'd5);
        check("rd_addr5", data_out, 32'hDEAD_BEEF);

        // Full sweep.
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 32'(i) * 32'h1111_1111);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            check($sformatf("sweep_%0d", i), data_out, 32'(i) * 32'h1111_1111);
        end

        // Back-to-back overwrite of addr 7; addr 6 untouched.
        do_write(3'd7, 32'h0000_0001);
        do_write(3'd7, 32'h0000_0002);
        do_read(3'd7);
        check("overwrite_addr7", data_out, 32'h0000_0002);
        do_read(3'd6);
        check("neighbor_addr6", data_out, 32'h6666_6666);

        // Asynchronous reset between edges clears data_out before the next edge.
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_out", data_out, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            check($sformatf("post_reset_read_%0d", i), data_out, 32'h0);
        end

        // First edge after reset performs a normal access.
        do_write(3'd4, 32'h1234_5678);
        do_read(3'd4);
        check("post_reset_wr_rd", data_out, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/single_port_memory_module.md
SINGLE_PORT_MEMORY_MODULE -- requirements
Module: single_port_memory_module

Interface
REQ-001 The block SHALL have parameter `width`, default 32: data word width in bits.
REQ-002 The block SHALL have parameter `depth`, default 8: number of words stored.
REQ-003 The block SHALL have a derived localparam `AW` = max(1, ceil(log2(depth))): address width (3 at defaults).
REQ-004 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port `we`, input, 1 bit: write enable; 1 = write, 0 = read.
REQ-007 The block SHALL have port `addr`, input, AW bits: word address for both write and read.
REQ-008 The block SHALL have port `data_in`, input, `width` bits: write data.
REQ-009 The block SHALL have port `data_out`, output, `width` bits: registered read data.

Function
REQ-010 Storage SHALL be `depth` words of `width` bits, indexed 0..depth-1.
REQ-011 When `we`=1 at a rising `clk` edge with `addr` < `depth`, `data_in` SHALL be stored at `mem[addr]`.
REQ-012 When `we`=0 at a rising `clk` edge with `addr` < `depth`, `data_out` SHALL load `mem[addr]`.
REQ-013 Read latency SHALL be exactly one clock: data is sampled at edge N and valid on `data_out` after edge N, until the next edge.
REQ-014 `data_out` SHALL NOT be combinationally dependent on `addr`, `we` or `data_in`.
REQ-015 During a write cycle (`we`=1), `data_out` SHALL hold its previous value (no-change mode).
REQ-016 A location written at edge N SHALL return the new value on a read sampled at edge N+1 or later.
REQ-017 Writes to `addr` >= `depth` SHALL be ignored, with no memory location modified.
REQ-018 Reads from `addr` >= `depth` SHALL load all-zeros into `data_out`.
REQ-019 Unwritten locations SHALL read as zero after reset.
REQ-020 Only one access SHALL occur per cycle; `we` selects write or read exclusively.
REQ-021 The block SHALL contain no other state and no handshake; it is always ready.

Reset
REQ-022 While `rst`=1, `data_out` SHALL be 0 immediately, with no clock required.
REQ-023 While `rst`=1, all memory words SHALL be 0.
REQ-024 While `rst`=1, writes and reads SHALL be blocked.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight access; no partial write is permitted.
REQ-026 After `rst` deasserts, the first rising edge SHALL perform a normal access.

Verification
REQ-027 Reset check: pulse `rst`=1 → `data_out`=0 immediately; reads of addr 0..7 all return 32'h0.
REQ-028 Write/read check: `we`=1, `addr`=3, `data_in`=32'hA5A5A5A5 for one edge; then `we`=0, `addr`=3 → `data_out`=32'hA5A5A5A5 one edge later.
REQ-029 Full sweep check: write `addr`*32'h11111111 to addr 0..7, then read back each → matching value one cycle after each read address.
REQ-030 No-change-on-write check: after reading addr 3 (A5A5A5A5), write 32'hDEADBEEF to addr 5 → `data_out` stays 32'hA5A5A5A5 during the write; reading addr 5 then returns 32'hDEADBEEF.
REQ-031 Overwrite check: write 32'h1 then 32'h2 to addr 7 on consecutive edges → read returns 32'h2; addr 6 is unchanged.
REQ-032 Async reset check: assert `rst` between clock edges after filling memory → `data_out`=0 before the next edge; subsequent reads return 0.
